// File: rtl/histogram_cdf.sv
// Gray-level histogram: saturating per-bin counters, pipelined increments, registered reads.
// Optional HISTOGRAM_CDF_EN adds a BUILD sweep that fills a cumulative-sum RAM readable via iRdCdf.
module histogram_cdf #(
   parameter int PIX_W = 8,
   parameter int CNT_W = 20
) (
   input  logic             iClk,
   input  logic             iReset,
   input  logic             iClear,
   input  logic             iInc,
   input  logic [PIX_W-1:0] iGray,
   output logic [PIX_W-1:0] oGray,
   input  logic             iRdEn,
   input  logic [PIX_W-1:0] iRdAddr,
   input  logic             iRdCdf,
   input  logic             iBuild,
   output logic [CNT_W-1:0] oRdData,
   output logic             oRdValid,
   output logic             oBusy,
   output logic [CNT_W-1:0] oTotal,
   output logic [1:0]       dbg_state
);

   localparam int BINS = 2**PIX_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PIX_W:0]   SWP_ONE  = (PIX_W+1)'(1);
   localparam logic [PIX_W:0]   CLR_LAST = (PIX_W+1)'(BINS - 1);

   // Handshake: iInc and iRdEn are single-cycle strobes, taken on any rising edge
   // where oBusy is low; there is no backpressure beyond oBusy. oRdValid is a
   // one-cycle pulse two cycles after an accepted iRdEn.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_BUILD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PIX_W:0]   sweep_q, sweep_d;

   logic [CNT_W-1:0] bin_ram [BINS];

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q + SWP_ONE;
      if (iClear) begin
         state_d = ST_CLEAR;
         sweep_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sweep_d = '0;
`ifdef HISTOGRAM_CDF_EN
               if (iBuild) state_d = ST_BUILD;
`endif
            end
            ST_CLEAR: begin
               if (sweep_q == CLR_LAST) begin
                  state_d = ST_IDLE;
                  sweep_d = '0;
               end
            end
`ifdef HISTOGRAM_CDF_EN
            ST_BUILD: begin
               if (sweep_q == (PIX_W+1)'(BINS + 1)) begin
                  state_d = ST_IDLE;
                  sweep_d = '0;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
               sweep_d = '0;
            end
         endcase
      end
   end

   // Reset lands in CLEAR so the unreset RAM is zeroed before first use.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   assign oBusy     = (state_q != ST_IDLE);
   assign dbg_state = state_q;

   // ------------------------------------------------- increment pipeline
   logic             acc;
   logic             s1_v, s2_v;
   logic [PIX_W-1:0] s1_bin, s2_bin;
   logic [CNT_W-1:0] s2_cnt, s2_new, s1_rd;

   assign acc    = iInc && !oBusy;
   assign s2_new = (s2_cnt == CNT_MAX) ? s2_cnt : s2_cnt + CNT_ONE;
   // Stage 2 commits at the end of this cycle, so a same-bin read must take its result.
   assign s1_rd  = (s2_v && (s2_bin == s1_bin)) ? s2_new : bin_ram[s1_bin];

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         oGray  <= '0;
         s1_v   <= 1'b0;
         s1_bin <= '0;
         s2_v   <= 1'b0;
         s2_bin <= '0;
         s2_cnt <= '0;
         oTotal <= '0;
      end else begin
         oGray  <= iGray;
         s1_v   <= acc && !iClear;
         s1_bin <= iGray;
         s2_v   <= s1_v && !iClear;
         s2_bin <= s1_bin;
         s2_cnt <= s1_rd;
         if (iClear) begin
            oTotal <= '0;
         end else if (acc && (oTotal != CNT_MAX)) begin
            oTotal <= oTotal + CNT_ONE;
         end
      end
   end

   logic             bin_we;
   logic [PIX_W-1:0] bin_wa;
   logic [CNT_W-1:0] bin_wd;

   always_comb begin
      bin_we = 1'b0;
      bin_wa = s2_bin;
      bin_wd = s2_new;
      if (state_q == ST_CLEAR) begin
         bin_we = 1'b1;
         bin_wa = sweep_q[PIX_W-1:0];
         bin_wd = '0;
      end else if (s2_v && !iClear) begin
         bin_we = 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (bin_we) bin_ram[bin_wa] <= bin_wd;
   end

   // ------------------------------------------------------- read port
   logic             rd1_v;
   logic [PIX_W-1:0] rd1_addr;
   logic [CNT_W-1:0] rd_word;

`ifdef HISTOGRAM_CDF_EN
   logic [CNT_W-1:0] cdf_ram [BINS];
   logic             rd1_cdf;

   assign rd_word = rd1_cdf ? cdf_ram[rd1_addr] : bin_ram[rd1_addr];
`else
   logic unused_cfg;

   assign unused_cfg = iBuild ^ iRdCdf;
   assign rd_word    = bin_ram[rd1_addr];
`endif

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rd1_v    <= 1'b0;
         rd1_addr <= '0;
         oRdValid <= 1'b0;
         oRdData  <= '0;
      end else begin
         rd1_v    <= iRdEn && !oBusy;
         rd1_addr <= iRdAddr;
         oRdValid <= rd1_v;
         if (rd1_v) oRdData <= rd_word;
      end
   end

`ifdef HISTOGRAM_CDF_EN
   // ------------------------------------------------------ CDF build
   // Three stages: read bin k, accumulate, write cdf[k]; BINS+2 cycles in total.
   logic             b_rd_en;
   logic [PIX_W-1:0] b_addr;
   logic [CNT_W-1:0] b_base, b_fwd;
   logic             ba_v, bb_v;
   logic [PIX_W-1:0] ba_addr, bb_addr;
   logic [CNT_W-1:0] ba_cnt, run_q;
   logic [CNT_W:0]   run_sum;

   assign b_rd_en = (state_q == ST_BUILD) && !sweep_q[PIX_W];
   assign b_addr  = sweep_q[PIX_W-1:0];
   // Increments accepted just before BUILD are still in flight; fold them in here.
   assign b_base  = (s2_v && (s2_bin == b_addr)) ? s2_new : bin_ram[b_addr];
   assign b_fwd   = (s1_v && (s1_bin == b_addr) && (b_base != CNT_MAX)) ?
                    b_base + CNT_ONE : b_base;
   assign run_sum = {1'b0, run_q} + {1'b0, ba_cnt};

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rd1_cdf <= 1'b0;
         ba_v    <= 1'b0;
         ba_addr <= '0;
         ba_cnt  <= '0;
         bb_v    <= 1'b0;
         bb_addr <= '0;
         run_q   <= '0;
      end else begin
         rd1_cdf <= iRdCdf;
         ba_v    <= b_rd_en && !iClear;
         ba_addr <= b_addr;
         ba_cnt  <= b_fwd;
         bb_v    <= ba_v && !iClear;
         bb_addr <= ba_addr;
         if (state_q != ST_BUILD) begin
            run_q <= '0;
         end else if (ba_v) begin
            run_q <= run_sum[CNT_W] ? CNT_MAX : run_sum[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (bb_v && !iClear) cdf_ram[bb_addr] <= run_q;
   end
`endif

endmodule

// File: tb/tb_histogram_cdf.sv
// Randomised and directed bench for histogram_cdf against a count-level reference model.
module tb_histogram_cdf;
   localparam int BINS = 256;
   localparam int MAXV = (1 << 20) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        clr = 0, inc = 0, rd_en = 0, rd_cdf = 0, build = 0;
   logic [7:0]  gray = 0, rd_addr = 0;
   logic [7:0]  o_gray;
   logic [19:0] rd_data, total;
   logic        rd_valid, busy;
   logic [1:0]  st;

   logic        s_clr = 0, s_inc = 0, s_rd_en = 0, s_rd_cdf = 0, s_build = 0;
   logic [7:0]  s_gray = 0, s_rd_addr = 0;
   logic [7:0]  s_o_gray;
   logic [3:0]  s_rd_data, s_total;
   logic        s_rd_valid, s_busy;
   logic [1:0]  s_st;

   histogram_cdf #(.PIX_W(8), .CNT_W(20)) dut (
      .iClk(clk), .iReset(rst), .iClear(clr), .iInc(inc), .iGray(gray), .oGray(o_gray),
      .iRdEn(rd_en), .iRdAddr(rd_addr), .iRdCdf(rd_cdf), .iBuild(build),
      .oRdData(rd_data), .oRdValid(rd_valid), .oBusy(busy), .oTotal(total), .dbg_state(st));

   histogram_cdf #(.PIX_W(8), .CNT_W(4)) dut_sat (
      .iClk(clk), .iReset(rst), .iClear(s_clr), .iInc(s_inc), .iGray(s_gray), .oGray(s_o_gray),
      .iRdEn(s_rd_en), .iRdAddr(s_rd_addr), .iRdCdf(s_rd_cdf), .iBuild(s_build),
      .oRdData(s_rd_data), .oRdValid(s_rd_valid), .oBusy(s_busy), .oTotal(s_total), .dbg_state(s_st));

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   // ------------------------------------------------ reference model
   typedef struct { int c; int b; } acc_t;
   typedef struct { int due; int addr; int lo; int hi; bit chk; } rd_t;

   int   bins_raw [BINS];
   int   cdf_m    [BINS];
   int   cdf_pend [BINS];
   bit   cdf_known = 0;
   bit   bld_act   = 0;
   int   m_total   = 0;
   int   busy_cnt  = 0;
   int   cyc       = 0;
   bit   busy_now;
   logic [7:0] gray_exp = 0;
   acc_t acc_q [$];
   rd_t  rdq   [$];

   // A read in cycle r must see every increment up to r-3; one from r-2 may or may not show.
   function automatic void bin_window(input int a, input int r, output int lo, output int hi);
      lo = bins_raw[a];
      hi = bins_raw[a];
      foreach (acc_q[i]) begin
         if (acc_q[i].b == a && acc_q[i].c >= r - 2) lo--;
         if (acc_q[i].b == a && acc_q[i].c == r - 1) hi--;
      end
      lo = sat(lo);
      hi = sat(hi);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         busy_cnt = BINS;
         m_total  = 0;
         gray_exp = 0;
         bld_act  = 0;
         rdq.delete();
         acc_q.delete();
         foreach (bins_raw[k]) bins_raw[k] = 0;
      end else begin
         rd_t r;
         busy_now = (busy_cnt > 0);
         if (rd_en && !busy_now) begin
            r.due  = cyc + 2;
            r.addr = int'(rd_addr);
            r.chk  = 1;
`ifdef HISTOGRAM_CDF_EN
            if (rd_cdf) begin
               r.chk = cdf_known;
               r.lo  = cdf_m[r.addr];
               r.hi  = cdf_m[r.addr];
            end else begin
               bin_window(r.addr, cyc, r.lo, r.hi);
            end
`else
            bin_window(r.addr, cyc, r.lo, r.hi);
`endif
            rdq.push_back(r);
         end
         gray_exp = gray;
         if (clr) begin
            busy_cnt = BINS;
            m_total  = 0;
            acc_q.delete();
            foreach (bins_raw[k]) bins_raw[k] = 0;
            if (bld_act) cdf_known = 0;
            bld_act = 0;
         end else begin
            if (inc && !busy_now) begin
               bins_raw[gray]++;
               m_total++;
               acc_q.push_back('{c: cyc, b: int'(gray)});
            end
            if (busy_now) begin
               busy_cnt--;
               if (busy_cnt == 0 && bld_act) begin
                  cdf_m     = cdf_pend;
                  cdf_known = 1;
                  bld_act   = 0;
               end
`ifdef HISTOGRAM_CDF_EN
            end else if (build) begin
               int run;
               run = 0;
               for (int k = 0; k < BINS; k++) begin
                  run = sat(run + sat(bins_raw[k]));
                  cdf_pend[k] = run;
               end
               busy_cnt = BINS + 2;
               bld_act  = 1;
`endif
            end
         end
         while (acc_q.size() > 0 && acc_q[0].c < cyc - 3) void'(acc_q.pop_front());
      end
      cyc++;
   end

   // ------------------------------------------------------ compare
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_busy", busy, 1);
         chk("rst_total", total, 0);
         chk("rst_rd_valid", rd_valid, 0);
         chk("rst_rd_data", rd_data, 0);
         chk("rst_gray", o_gray, 0);
      end else begin
         chk("busy", busy, busy_cnt > 0);
         chk("gray", o_gray, gray_exp);
         chk("total", total, sat(m_total));
         if (rdq.size() > 0 && rdq[0].due == cyc) begin
            rd_t r;
            r = rdq.pop_front();
            chk("rd_valid", rd_valid, 1);
            if (r.chk) begin
               n_total++;
               if (int'(rd_data) < r.lo || int'(rd_data) > r.hi) begin
                  n_bad++;
                  $display("FAIL rd_data addr %0d: got %0d expected %0d..%0d",
                           r.addr, rd_data, r.lo, r.hi);
               end
            end
         end else begin
            chk("rd_valid_idle", rd_valid, 0);
         end
      end
   end

   // ------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(input int start, output int n);
      n = start;
      while (busy && n < 1000) begin
         n++;
         tick();
      end
      if (busy) begin
         n_total++;
         n_bad++;
         $display("FAIL busy_timeout: got busy after %0d cycles expected idle", n);
      end
   endtask

   task automatic do_read(input int a, input bit cdf, output int data);
      rd_en   = 1;
      rd_addr = 8'(a);
      rd_cdf  = cdf;
      tick();
      rd_en  = 0;
      rd_cdf = 0;
      tick();
      chk("lit_rd_valid", rd_valid, 1);
      data = int'(rd_data);
   endtask

   task automatic pulse_clear();
      int n;
      clr = 1;
      tick();
      clr = 0;
      count_busy(0, n);
      chk("clear_busy_cycles", n, 256);
   endtask

   task automatic inc_seq(input int b);
      inc  = 1;
      gray = 8'(b);
      tick();
      inc = 0;
   endtask

   initial begin
      int n, d;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      count_busy(0, n);
      chk("reset_busy_cycles", n, 256);
      do_read(0, 0, d);   chk("reset_bin0", d, 0);
      do_read(128, 0, d); chk("reset_bin128", d, 0);
      do_read(255, 0, d); chk("reset_bin255", d, 0);

      for (int i = 0; i < 10; i++) begin
         inc = 1; gray = 8'd5; tick();
      end
      inc = 0;
      repeat (3) tick();
      do_read(5, 0, d);
      chk("burst_bin5", d, 10);
      chk("burst_total", total, 10);

      pulse_clear();
      inc_seq(7); inc = 1; gray = 8'd7; tick(); gray = 8'd8; tick(); gray = 8'd7; tick();
      inc = 0;
      repeat (3) tick();
      do_read(7, 0, d); chk("ilv_bin7", d, 3);
      do_read(8, 0, d); chk("ilv_bin8", d, 1);
      chk("ilv_total", total, 4);

      for (int i = 0; i < 20; i++) begin
         s_inc = 1; s_gray = 8'd3; tick();
      end
      s_inc = 0;
      repeat (3) tick();
      s_rd_en = 1; s_rd_addr = 8'd3; tick();
      s_rd_en = 0; tick();
      chk("sat_valid", s_rd_valid, 1);
      chk("sat_bin3", s_rd_data, 15);
      chk("sat_total", s_total, 15);

      n = 0;
      for (int i = 0; i < 12; i++) begin
         inc = 1; gray = 8'd9; clr = (i == 4);
         if (busy) n++;
         tick();
      end
      inc = 0; clr = 0;
      count_busy(n, n);
      chk("midclr_busy_cycles", n, 256);
      chk("midclr_total", total, 0);
      do_read(9, 0, d); chk("midclr_bin9", d, 0);
      for (int a = 0; a < BINS; a++) begin
         rd_en = 1; rd_addr = 8'(a); tick();
      end
      rd_en = 0;
      repeat (3) tick();

      pulse_clear();
      inc_seq(0); inc_seq(0); inc_seq(1); inc_seq(1); inc_seq(1); inc_seq(255);
      build = 1; tick(); build = 0;
`ifdef HISTOGRAM_CDF_EN
      count_busy(0, n);
      chk("build_busy_cycles", n, 258);
      do_read(0, 1, d);   chk("cdf0", d, 2);
      do_read(1, 1, d);   chk("cdf1", d, 5);
      do_read(254, 1, d); chk("cdf254", d, 5);
      do_read(255, 1, d); chk("cdf255", d, 6);
      do_read(1, 0, d);   chk("post_build_bin1", d, 3);
`else
      chk("build_ignored", busy, 0);
      do_read(1, 1, d);   chk("rdcdf_ignored_bin1", d, 3);
`endif

      for (int i = 0; i < 3000; i++) begin
         inc     = ($urandom_range(0, 9) < 7);
         gray    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         rd_en   = ($urandom_range(0, 3) == 0);
         rd_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         rd_cdf  = ($urandom_range(0, 1) == 1);
         clr     = ($urandom_range(0, 999) == 0);
         build   = ($urandom_range(0, 299) == 0);
         tick();
      end
      inc = 0; rd_en = 0; rd_cdf = 0; clr = 0; build = 0;
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
